// File: rtl/mem_wb_skid_pipe_if.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_pipe_if
// Valid/ready beat bus carrying one MEM->WB payload.
//   valid, ready     : handshake (master drives valid, slave drives ready)
//   alu, load        : ALU result and load data, XLEN bits each
//   rd               : destination register index
//   wb, memtoreg     : register write enable, writeback-select
//   sb               : opaque branch-observation sideband, passed through
// The stage uses the slave modport on its MEM side and the master modport
// on its WB side.
// -----------------------------------------------------------------------------
interface mem_wb_skid_pipe_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int SB_W  = 66
);
    logic             valid;
    logic             ready;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  load;
    logic [REG_W-1:0] rd;
    logic             wb;
    logic             memtoreg;
    logic [SB_W-1:0]  sb;

    modport master (
        output valid, alu, load, rd, wb, memtoreg, sb,
        input  ready
    );

    modport slave (
        input  valid, alu, load, rd, wb, memtoreg, sb,
        output ready
    );
endinterface

// File: rtl/mem_wb_skid_pipe.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_pipe
// MEM->WB pipeline stage built as a two-entry skid buffer. The head entry H
// drives the WB side; the skid entry S absorbs one extra beat so that the
// MEM-side ready is a pure function of registered state and never depends
// combinationally on WB's ready.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush_i         : synchronous kill of every buffered entry
//   in_s            : MEM-side beat bus (slave)
//   out_m           : WB-side beat bus (master), payload of the head entry
//   out_wdata_o     : head entry's writeback value (load or alu)
//   rs1_i, rs2_i    : forwarding lookup register indices
//   fwdN_hit_o      : lookup N matched a buffered register writer
//   fwdN_data_o     : forwarded value for lookup N, zero on miss
//   occupancy_o     : number of valid entries (0..2)
// -----------------------------------------------------------------------------
module mem_wb_skid_pipe #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int SB_W  = 66
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    mem_wb_skid_pipe_if.slave     in_s,
    mem_wb_skid_pipe_if.master    out_m,
    output logic [XLEN-1:0]       out_wdata_o,
    input  logic [REG_W-1:0]      rs1_i,
    input  logic [REG_W-1:0]      rs2_i,
    output logic                  fwd1_hit_o,
    output logic [XLEN-1:0]       fwd1_data_o,
    output logic                  fwd2_hit_o,
    output logic [XLEN-1:0]       fwd2_data_o,
    output logic [1:0]            occupancy_o
);

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  load;
        logic [REG_W-1:0] rd;
        logic             wb;
        logic             memtoreg;
        logic [SB_W-1:0]  sb;
    } entry_t;

    // An invalid entry is always all-zero, so clearing means loading this.
    localparam entry_t ENTRY_CLR = '0;

    entry_t h_q;
    entry_t h_d;
    entry_t s_q;
    entry_t s_d;
    entry_t in_entry_s;
    logic   acc_s;
    logic   fire_s;
    logic [XLEN:0] fwd1_s;
    logic [XLEN:0] fwd2_s;

    // Writeback value an entry would deliver.
    function automatic logic [XLEN-1:0] entry_wdata(input entry_t e);
        return e.memtoreg ? e.load : e.alu;
    endfunction

    // Entry is a live writer of a nonzero register equal to rs.
    function automatic logic entry_hits(input entry_t e, input logic [REG_W-1:0] rs);
        return e.valid & e.wb & (e.rd != {REG_W{1'b0}}) & (e.rd == rs);
    endfunction

    // Forwarding lookup {hit, data}; S is younger than H so it wins.
    function automatic logic [XLEN:0] fwd_lookup(input entry_t h, input entry_t s,
                                                 input logic [REG_W-1:0] rs);
        logic [XLEN:0] r;
        if (entry_hits(s, rs)) begin
            r = {1'b1, entry_wdata(s)};
        end else if (entry_hits(h, rs)) begin
            r = {1'b1, entry_wdata(h)};
        end else begin
            r = {1'b0, {XLEN{1'b0}}};
        end
        return r;
    endfunction

    assign in_entry_s = '{valid:    1'b1,
                          alu:      in_s.alu,
                          load:     in_s.load,
                          rd:       in_s.rd,
                          wb:       in_s.wb,
                          memtoreg: in_s.memtoreg,
                          sb:       in_s.sb};

    // Ready is taken from the skid valid bit only: no path from WB's ready.
    assign in_s.ready = ~s_q.valid;
    assign acc_s      = in_s.valid & ~s_q.valid;
    assign fire_s     = h_q.valid & out_m.ready;

    // Next-state of the two entries; flush overrides accept and transfer.
    always_comb begin
        h_d = h_q;
        s_d = s_q;
        if (flush_i) begin
            h_d = ENTRY_CLR;
            s_d = ENTRY_CLR;
        end else begin
            case ({h_q.valid, s_q.valid})
                2'b00: begin
                    if (acc_s) begin
                        h_d = in_entry_s;
                    end else begin
                        h_d = h_q;
                    end
                end
                2'b10: begin
                    if (acc_s && !fire_s) begin
                        s_d = in_entry_s;
                    end else if (acc_s && fire_s) begin
                        h_d = in_entry_s;
                    end else if (fire_s) begin
                        h_d = ENTRY_CLR;
                    end else begin
                        h_d = h_q;
                    end
                end
                2'b11: begin
                    if (fire_s) begin
                        h_d = s_q;
                        s_d = ENTRY_CLR;
                    end else begin
                        h_d = h_q;
                    end
                end
                default: begin
                    // H empty with S valid cannot be reached; recover to EMPTY.
                    h_d = ENTRY_CLR;
                    s_d = ENTRY_CLR;
                end
            endcase
        end
    end

    // Entry registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= ENTRY_CLR;
            s_q <= ENTRY_CLR;
        end else begin
            h_q <= h_d;
            s_q <= s_d;
        end
    end

    assign out_m.valid    = h_q.valid;
    assign out_m.alu      = h_q.alu;
    assign out_m.load     = h_q.load;
    assign out_m.rd       = h_q.rd;
    assign out_m.wb       = h_q.wb;
    assign out_m.memtoreg = h_q.memtoreg;
    assign out_m.sb       = h_q.sb;
    assign out_wdata_o    = entry_wdata(h_q);

    assign fwd1_s      = fwd_lookup(h_q, s_q, rs1_i);
    assign fwd2_s      = fwd_lookup(h_q, s_q, rs2_i);
    assign fwd1_hit_o  = fwd1_s[XLEN];
    assign fwd1_data_o = fwd1_s[XLEN-1:0];
    assign fwd2_hit_o  = fwd2_s[XLEN];
    assign fwd2_data_o = fwd2_s[XLEN-1:0];

    assign occupancy_o = {1'b0, h_q.valid} + {1'b0, s_q.valid};

endmodule

// File: doc/mem_wb_skid_pipe.md
# mem_wb_skid_pipe

Parametrised MEM→WB pipeline stage using a valid/ready handshake and a two-entry skid buffer. It replaces the global enable/stall register between MEM and WB, so backpressure from WB never needs a combinational path back to MEM. It also provides a synchronous flush and register-file forwarding lookups for two source registers, searched across both buffered entries. It sits between the MEM stage and the register-file write port.

## Interface
- XLEN, 32, datapath width of ALU result and load data
- REG_W, 5, register index width
- SB_W, 66, opaque sideband width (branch observation info: modify_pc, update_pc, jump_addr, update_btb), passed through unchanged

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  MEM presents a beat
- in_ready  out  1  stage can accept a beat this cycle
- in_alu, in_load  in  XLEN  ALU result, load data
- in_rd  in  REG_W  destination register
- in_wb, in_memtoreg  in  1  register write enable, writeback-select
- in_sb  in  SB_W  sideband
- out_valid  out  1  WB beat available
- out_ready  in  1  WB consumes beat
- out_alu, out_load, out_rd, out_wb, out_memtoreg, out_sb  out  as input  payload of the head entry
- out_wdata  out  XLEN  out_memtoreg ? out_load : out_alu
- rs1, rs2  in  REG_W  forwarding lookup indices
- fwd1_hit, fwd2_hit  out  1  lookup matched a buffered writer
- fwd1_data, fwd2_data  out  XLEN  forwarded value; zero when no hit
- occupancy  out  2  number of valid entries (0..2)

## Operation
- Storage: head entry H (drives out_*) and skid entry S. Each entry has a valid bit and a payload.
- State is encoded by the valid bits: EMPTY (H=0, S=0), ONE (H=1, S=0), FULL (H=1, S=1). H=0 with S=1 is illegal and unreachable.
- in_ready = !S.valid. It is a register output with no combinational dependence on out_ready.
- out_valid = H.valid.
- Accept event: acc = in_valid & in_ready.
- Transfer event: fire = out_valid & out_ready.
- EMPTY:
  - acc → ONE, H ← in.
- ONE:
  - acc & !fire → FULL, S ← in.
  - acc & fire → ONE, H ← in.
  - fire & !acc → EMPTY.
  - otherwise hold.
- FULL (acc impossible):
  - fire → ONE, H ← S, S cleared.
  - otherwise hold.
- Cleared entry: whenever an entry becomes invalid, its payload is zeroed. An invalid entry always shows all-zero payload.
- Flush has priority over acc and fire:
  - Next state is EMPTY and all payloads are zeroed.
  - A beat accepted in the flush cycle is discarded.
  - A beat transferred in the flush cycle counts as delivered.
- Forwarding, per port n:
  - An entry E qualifies if E.valid & E.wb & E.rd != 0 & E.rd == rsn.
  - S has priority over H, because S is younger.
  - fwdn_data = qualifying entry's (memtoreg ? load : alu).
  - Purely combinational from registered state.
- occupancy = H.valid + S.valid.

## Timing
- Reset values, held while rst is high:
  - H and S invalid, all payloads 0.
  - out_valid=0, all out_* = 0, out_wdata=0.
  - occupancy=0, fwd*_hit=0, fwd*_data=0.
  - in_ready=1.
- Latency: an accepted beat appears on out_* on the next cycle when the stage was EMPTY, or when it was ONE with a transfer in that cycle.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, the stage accepts at most 2 beats, then in_ready drops in the cycle after the second acceptance.
  - in_ready rises the cycle after the first fire from FULL.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost, except beats killed by flush.
- Reset asserted mid-operation: all state is cleared asynchronously. The first acceptance is possible in the first cycle after deassertion.
- out_* must hold stable while out_valid=1 and out_ready=0.

## Test plan
- Streaming:
  - Stimulus: out_ready=1; beats alu=0x10,0x20,0x30 with rd=1,2,3 on consecutive cycles.
  - Response: out_alu shows 0x10,0x20,0x30 on cycles +1..+3; occupancy stays 1; in_ready stays 1.
- Backpressure fill/drain:
  - Stimulus: out_ready=0; send A=0xA, B=0xB, C=0xC.
  - Response: A and B are accepted; in_ready=0 the cycle after B, so C is held; occupancy=2.
  - Stimulus: raise out_ready.
  - Response: out_alu shows A, B, C in order; in_ready=1 one cycle after A fires.
- Flush in FULL:
  - Stimulus: FULL holding 0x1,0x2; flush=1 with in_valid=1, in_alu=0x3.
  - Response: next cycle occupancy=0, out_valid=0, all out_*=0; beat 0x3 is discarded.
- Forwarding priority:
  - Stimulus: H rd=5, wb=1, alu=0x55; S rd=5, wb=1, memtoreg=1, load=0x77; rs1=5.
  - Response: fwd1_hit=1, fwd1_data=0x77.
  - Stimulus: rs2=0 with an entry rd=0, wb=1.
  - Response: fwd2_hit=0, fwd2_data=0.
- Writeback select:
  - Stimulus: beat with memtoreg=1, load=0xDEAD, alu=0xBEEF.
  - Response: out_wdata=0xDEAD.
  - Stimulus: same beat with memtoreg=0.
  - Response: out_wdata=0xBEEF.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges while in FULL.
  - Response: out_valid=0, occupancy=0 and in_ready=1 immediately, without waiting for a clock edge; sideband out_sb=0.
